sketch_control: RTL and testbench
=================================

# sketch_control

Sequencing controller for the etch-a-sketch datapath. After reset it sweeps the whole 160x120 framebuffer to the background colour. It then runs a periodic move/plot loop: wait on the datapath timer, pulse the position counters once, and issue a single VGA plot write at the new pen position. It sits between the top level (switches, VGA adapter write port) and the datapath, and owns every datapath enable.

## Interface
- SCREEN_W, 160, horizontal pixel count; sweep x range is 0..SCREEN_W-1
- SCREEN_H, 120, vertical pixel count; sweep y range is 0..SCREEN_H-1
- MOVE_LIMIT, 26'd2_500_000, timer limit for normal speed (20 Hz at 50 MHz)
- BG_COLOUR, 3'b000, colour written during the clear sweep
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; forces state START and zeroes the counters
- clear_req  in  1  level, already synchronised to clk; a rising edge requests a screen clear
- fast  in  1  speed select
- pen_colour  in  3  colour for pen plots
- timer_done  in  1  datapath timer at-limit flag
- xpos  in  8  datapath x position
- ypos  in  8  datapath y position
- timer_en  out  1  datapath timer enable; the timer count clears while this is 0
- timer_limit  out  26  datapath timer limit
- pos_en  out  1  datapath position-counter enable
- plot  out  1  VGA write strobe, one pixel per cycle high
- vga_x  out  8  VGA write x
- vga_y  out  7  VGA write y
- colour  out  3  VGA write colour
- busy  out  1  high in START and CLEAR

## Operation
- States: START, CLEAR, WAIT, MOVE, SETTLE, PLOT.
- Outputs are Moore decodes of the state plus the sweep counters. Any output not listed for a state is 0.
- timer_limit = fast ? (MOVE_LIMIT >> 2) : MOVE_LIMIT. It is combinational, valid in every state, and a change takes effect in the same cycle.
- **START** (reset state):
  - busy=1.
  - Next state is CLEAR, unconditionally.
- **CLEAR**:
  - plot=1, vga_x=cx, vga_y=cy, colour=BG_COLOUR, busy=1.
  - cx increments each cycle. At cx=SCREEN_W-1, cx wraps to 0 and cy increments.
  - At (SCREEN_W-1, SCREEN_H-1): cx and cy return to 0 and the next state is WAIT.
  - One sweep writes exactly SCREEN_W*SCREEN_H pixels in raster order.
- **WAIT**:
  - timer_en=1.
  - If clear_pending=1: next state is CLEAR. This has priority over timer_done.
  - Else if timer_done=1: next state is MOVE.
  - Otherwise stay in WAIT.
- **MOVE**:
  - pos_en=1 for exactly one cycle, timer_en=0 (restarts the timer).
  - Next state is SETTLE.
- **SETTLE**:
  - One cycle with all outputs 0, while the registered xpos/ypos update.
  - Next state is PLOT.
- **PLOT**:
  - plot=1, vga_x=xpos, vga_y=ypos[6:0], colour=pen_colour.
  - Next state is WAIT.
- **clear_pending**:
  - clear_req_d is a one-cycle delayed copy of clear_req.
  - clear_pending is set on clear_req & ~clear_req_d in any state except START and CLEAR.
  - clear_pending is cleared on every entry to CLEAR.
  - A rising edge during START or CLEAR is ignored; that clear is already in progress.
- Reset mid-operation: every output drops to its START value immediately, asynchronously. The sweep restarts from (0,0) after reset is released.

## Timing
- Reset values: all outputs 0 except busy=1 and timer_limit (combinational).
- Internal reset values: cx=0, cy=0, clear_pending=0, clear_req_d=0.
- After reset release:
  - 1 START cycle.
  - 19200 CLEAR cycles with plot=1. First write (0,0), last write (159,119).
  - busy falls on the first WAIT cycle.
- timer_done sampled high in WAIT leads to:
  - pos_en=1 on the next cycle (MOVE).
  - plot=1 two cycles after that (PLOT).
  - WAIT again on the following cycle.
- Loop overhead: 3 cycles with timer_en=0 per move.
- A clear_req rising edge seen in MOVE, SETTLE or PLOT is serviced on the first WAIT cycle: CLEAR is entered on the next edge.
- A clear_req rising edge in WAIT enters CLEAR 2 cycles later: one cycle to register clear_pending, one to transition.

## Test plan
- **Reset and sweep:** release reset.
  - Expect busy=1.
  - Expect exactly 19200 plot pulses, colour=0, in raster order from (0,0) to (159,119).
  - Expect busy=0 and timer_en=1 on the next cycle.
- **Move/plot:** in WAIT, xpos=10, ypos=20 after the update, pen_colour=3'b101, pulse timer_done for one cycle.
  - Expect pos_en high for exactly 1 cycle.
  - Expect plot high for exactly 1 cycle, 2 cycles after pos_en, with vga_x=10, vga_y=20, colour=101.
  - Expect timer_en=0 for exactly 3 cycles.
- **Simultaneous events:** clear_pending=1 and timer_done=1 together in WAIT.
  - Expect CLEAR entered, pos_en never asserted, clear_pending=0 after entry.
- **Pending clear:** clear_req rises while in PLOT.
  - Expect one WAIT cycle, then a full 19200-pixel sweep.
  - A second rising edge during the sweep causes no extra sweep.
- **Reset mid-clear:** assert reset at pixel (50,30).
  - Expect plot=0 and busy=1 immediately.
  - After release, the sweep restarts at (0,0).
- **Speed select:** fast=0 gives timer_limit=2_500_000; fast=1 gives timer_limit=625_000. The change is visible in the same cycle in every state.

Source files
------------

// File: rtl/sketch_control.sv
// sketch_control: sequences screen clear sweep and timed move/plot loop for the etch-a-sketch datapath
module sketch_control #(
  parameter int          SCREEN_W   = 160,
  parameter int          SCREEN_H   = 120,
  parameter logic [25:0] MOVE_LIMIT = 26'd2_500_000,
  parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_req,
  input  logic        fast,
  input  logic [2:0]  pen_colour,
  input  logic        timer_done,
  input  logic [7:0]  xpos,
  input  logic [7:0]  ypos,
  output logic        timer_en,
  output logic [25:0] timer_limit,
  output logic        pos_en,
  output logic        plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  colour,
  output logic        busy
);
  localparam logic [2:0] START  = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] MOVE   = 3'd3;
  localparam logic [2:0] SETTLE = 3'd4;
  localparam logic [2:0] PLOT   = 3'd5;
  localparam logic [7:0] X_MAX  = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_MAX  = 7'(SCREEN_H - 1);

  logic [2:0] state, next;
  logic [7:0] cx;
  logic [6:0] cy;
  logic       clear_pending, clear_req_d;
  logic       last_x, last_y, rise;
  logic       unused_ypos;

  assign unused_ypos = ypos[7];
  assign last_x      = cx == X_MAX;
  assign last_y      = cy == Y_MAX;
  assign rise        = clear_req & ~clear_req_d;
  assign timer_limit = fast ? (MOVE_LIMIT >> 2) : MOVE_LIMIT;

  always_comb begin
    next = START;
    case (state)
      START:   next = CLEAR;
      CLEAR:   next = (last_x && last_y) ? WAIT : CLEAR;
      WAIT:    next = clear_pending ? CLEAR : timer_done ? MOVE : WAIT;
      MOVE:    next = SETTLE;
      SETTLE:  next = PLOT;
      PLOT:    next = WAIT;
      default: next = START;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= START;
      cx            <= '0;
      cy            <= '0;
      clear_pending <= 1'b0;
      clear_req_d   <= 1'b0;
    end else begin
      state       <= next;
      clear_req_d <= clear_req;
      if (next == CLEAR && state != CLEAR)
        clear_pending <= 1'b0;
      else if (rise && state != START && state != CLEAR)
        clear_pending <= 1'b1;
      if (state == CLEAR) begin
        cx <= last_x ? '0 : cx + 8'd1;
        if (last_x) cy <= last_y ? '0 : cy + 7'd1;
      end
    end
  end

  always_comb begin
    plot     = state == CLEAR || state == PLOT;
    busy     = state == START || state == CLEAR;
    timer_en = state == WAIT;
    pos_en   = state == MOVE;
    vga_x    = state == CLEAR ? cx : state == PLOT ? xpos : '0;
    vga_y    = state == CLEAR ? cy : state == PLOT ? ypos[6:0] : '0;
    colour   = state == CLEAR ? BG_COLOUR : state == PLOT ? pen_colour : '0;
  end
endmodule

// File: tb/tb_sketch_control.sv
// tb_sketch_control: directed self-checking bench for sketch_control
module tb_sketch_control;
  logic        clk, reset, clear_req, fast, timer_done;
  logic [2:0]  pen_colour;
  logic [7:0]  xpos, ypos;
  logic        timer_en, pos_en, plot, busy;
  logic [25:0] timer_limit;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  colour;
  int total = 0;
  int bad = 0;

  sketch_control dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .fast(fast),
    .pen_colour(pen_colour), .timer_done(timer_done), .xpos(xpos), .ypos(ypos),
    .timer_en(timer_en), .timer_limit(timer_limit), .pos_en(pos_en), .plot(plot),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // checks n consecutive clear cycles starting at raster index start
  task automatic sweep(input int start, input int n, input string tag);
    int e;
    e = 0;
    for (int i = start; i < start + n; i++) begin
      @(negedge clk);
      if (plot !== 1'b1 || busy !== 1'b1 || pos_en !== 1'b0 || timer_en !== 1'b0 ||
          colour !== 3'b000 || vga_x !== 8'(i % 160) || vga_y !== 7'(i / 160))
        e++;
    end
    chk(tag, e, 0);
  endtask

  task automatic wait_state(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timer_en"}, timer_en, 1);
    chk({tag, "_plot"}, plot, 0);
    chk({tag, "_pos_en"}, pos_en, 0);
  endtask

  task automatic move_plot(input string tag);
    timer_done = 1;
    @(negedge clk);
    timer_done = 0;
    chk({tag, "_move_pos_en"}, pos_en, 1);
    chk({tag, "_move_timer_en"}, timer_en, 0);
    chk({tag, "_move_plot"}, plot, 0);
    @(negedge clk);
    chk({tag, "_settle_outs"}, {pos_en, timer_en, plot, busy, vga_x, vga_y, colour}, 0);
    @(negedge clk);
    chk({tag, "_plot"}, plot, 1);
    chk({tag, "_plot_pos_en"}, pos_en, 0);
    chk({tag, "_plot_timer_en"}, timer_en, 0);
    chk({tag, "_plot_x"}, vga_x, 10);
    chk({tag, "_plot_y"}, vga_y, 20);
    chk({tag, "_plot_colour"}, colour, 3'b101);
  endtask

  initial begin
    reset = 1; clear_req = 0; fast = 0; timer_done = 0;
    pen_colour = 3'b101; xpos = 8'd10; ypos = 8'd20;
    #2 reset = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_plot", plot, 0);
    chk("rst_timer_en", timer_en, 0);
    chk("rst_pos_en", pos_en, 0);
    chk("rst_vga", {vga_x, vga_y, colour}, 0);
    chk("rst_limit_slow", timer_limit, 2_500_000);
    fast = 1; #1;
    chk("rst_limit_fast", timer_limit, 625_000);
    fast = 0; #1;
    chk("rst_limit_back", timer_limit, 2_500_000);

    @(negedge clk);
    reset = 1; #1;
    chk("start_busy", busy, 1);
    chk("start_plot", plot, 0);
    sweep(0, 19200, "sweep1");
    @(negedge clk);
    wait_state("wait1");

    fast = 1; #1;
    chk("wait_limit_fast", timer_limit, 625_000);
    fast = 0; #1;
    move_plot("mp1");
    @(negedge clk);
    wait_state("wait2");

    // clear request rising during PLOT: one WAIT cycle, then a sweep
    timer_done = 1;
    @(negedge clk);
    timer_done = 0;
    fast = 1; #1;
    chk("move_limit_fast", timer_limit, 625_000);
    fast = 0;
    @(negedge clk);
    @(negedge clk);
    chk("pend_in_plot", plot, 1);
    clear_req = 1;
    @(negedge clk);
    wait_state("pend_wait");
    sweep(0, 100, "pend_sweep_a");
    clear_req = 0;
    sweep(100, 100, "pend_sweep_b");
    clear_req = 1;
    sweep(200, 19000, "pend_sweep_c");
    @(negedge clk);
    wait_state("pend_done");
    repeat (3) @(negedge clk);
    wait_state("no_extra_sweep");

    // clear pending and timer_done together in WAIT
    clear_req = 0;
    @(negedge clk);
    clear_req = 1;
    @(negedge clk);
    wait_state("sim_wait");
    chk("sim_pending_set", dut.clear_pending, 1);
    timer_done = 1;
    sweep(0, 1, "sim_clear_entry");
    timer_done = 0;
    chk("sim_pending_clr", dut.clear_pending, 0);

    // reset while the sweep sits at pixel (50,30)
    sweep(1, 4850, "mid_sweep");
    chk("mid_at_pixel", {vga_x, 1'b0, vga_y}, {8'd50, 1'b0, 7'd30});
    reset = 0; #1;
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_vga", {vga_x, vga_y}, 0);
    @(negedge clk);
    reset = 1; #1;
    chk("mid_start_busy", busy, 1);
    chk("mid_start_plot", plot, 0);
    sweep(0, 19200, "resweep");
    @(negedge clk);
    wait_state("resweep_done");
    move_plot("mp2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
